// File: rtl/cpu_axi_bridge.sv
// rtl/cpu_axi_bridge.sv - two SRAM-like CPU ports to single-outstanding AXI master
// Define BRIDGE_DATA_PRIO_EN for fixed data-port priority; default is round-robin.
module cpu_axi_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [1:0]            wr,
    input  logic [3:0]            size,
    input  logic [7:0]            wstrb,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [63:0]           wdata,
    output logic [1:0]            addr_ok,
    output logic [1:0]            data_ok,
    output logic [31:0]           rdata,
    output logic [ADDR_W-1:0]     araddr,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [31:0]           rdata_axi,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [2:0]            awsize,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [31:0]           wdata_axi,
    output logic [3:0]            wstrb_axi,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW_W = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0]        state;
    logic              grant_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [3:0]        wstrb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              aw_done;
    logic              w_done;
    logic              grant_idx;
    logic              any_req;

`ifdef BRIDGE_DATA_PRIO_EN
    always_comb begin
        any_req   = |req;
        grant_idx = req[1];
    end
`else
    logic rr_ptr;

    // rr_ptr names the tie winner; a lone request always wins outright
    always_comb begin
        any_req   = |req;
        grant_idx = (req == 2'b11) ? rr_ptr : req[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b1;
        end else if (state == S_IDLE && any_req) begin
            rr_ptr <= ~grant_idx;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            grant_q <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            wstrb_q <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant_q <= grant_idx;
                        wr_q    <= wr[grant_idx];
                        size_q  <= grant_idx ? size[3:2] : size[1:0];
                        wstrb_q <= grant_idx ? wstrb[7:4] : wstrb[3:0];
                        addr_q  <= grant_idx ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
                        wdata_q <= grant_idx ? wdata[63:32] : wdata[31:0];
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= wr[grant_idx] ? S_AW_W : S_AR;
                    end
                end
                S_AR: begin
                    if (arready) state <= S_R;
                end
                S_R: begin
                    if (rvalid) begin
                        rdata_q <= rdata_axi;
                        state   <= S_RESP;
                    end
                end
                S_AW_W: begin
                    if (awready) aw_done <= 1'b1;
                    if (wready)  w_done  <= 1'b1;
                    // either channel may finish first; leave once both have
                    if ((aw_done || awready) && (w_done || wready)) state <= S_B;
                end
                S_B: begin
                    if (bvalid) state <= S_RESP;
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign addr_ok   = (state == S_IDLE && any_req) ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
    assign data_ok   = (state == S_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign rdata     = rdata_q;
    assign araddr    = addr_q;
    assign arsize    = {1'b0, size_q};
    assign arvalid   = (state == S_AR);
    assign rready    = (state == S_R);
    assign awaddr    = addr_q;
    assign awsize    = {1'b0, size_q};
    assign awvalid   = (state == S_AW_W) && !aw_done;
    assign wvalid    = (state == S_AW_W) && !w_done;
    assign wdata_axi = wdata_q;
    assign wstrb_axi = wstrb_q;
    assign bready    = (state == S_B);

    logic unused_wr_q;
    assign unused_wr_q = wr_q;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb/tb_cpu_axi_bridge.sv - directed self-checking bench for cpu_axi_bridge
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, wr;
    logic [3:0]  size;
    logic [7:0]  wstrb;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  addr_ok, data_ok;
    logic [31:0] rdata;
    logic [31:0] araddr, awaddr;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] rdata_axi, wdata_axi;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb_axi;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_axi_bridge #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata_axi(rdata_axi), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata_axi(wdata_axi), .wstrb_axi(wstrb_axi), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // inputs change on the falling edge; outputs are sampled 1 time unit later
    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        req = 2'b00; wr = 2'b00; size = 4'b1010; wstrb = 8'h00;
        addr = 64'd0; wdata = 64'd0;
        arready = 1'b0; rvalid = 1'b0; rdata_axi = 32'd0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        step();
        step();
        reset = 1'b0;
        settle();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_addr_ok"}, addr_ok, 2'b00);
        chk({tag, "_data_ok"}, data_ok, 2'b00);
        chk({tag, "_valids"}, {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
        chk({tag, "_rdata"}, rdata, 32'd0);
    endtask

    logic exp_second;

    initial begin
        reset = 1'b1;
        do_reset();
        chk_idle_outputs("reset");

        // single instruction read, slave always ready
        step();
        req = 2'b01; wr = 2'b00; addr[31:0] = 32'h1C000000;
        arready = 1'b1; rvalid = 1'b1; rdata_axi = 32'h02800C0C;
        settle();
        chk("rd_addr_ok", addr_ok, 2'b01);
        step(); req = 2'b00; settle();
        chk("rd_arvalid", arvalid, 1'b1);
        chk("rd_araddr", araddr, 32'h1C000000);
        chk("rd_arsize", arsize, 3'd2);
        step(); settle();
        chk("rd_rready", rready, 1'b1);
        step(); settle();
        chk("rd_data_ok", data_ok, 2'b01);
        chk("rd_rdata", rdata, 32'h02800C0C);
        step(); rdata_axi = 32'hDEADBEEF; settle();
        chk("rd_data_ok_pulse", data_ok, 2'b00);
        chk("rd_rdata_hold", rdata, 32'h02800C0C);

        // data byte write, wready later than awready
        arready = 1'b0; rvalid = 1'b0;
        step();
        req = 2'b10; wr = 2'b10; size = 4'b0010; wstrb = 8'h20;
        addr[63:32] = 32'h1C0001F1; wdata[63:32] = 32'h0000AB00;
        settle();
        chk("wr_addr_ok", addr_ok, 2'b10);
        step(); req = 2'b00; awready = 1'b1; settle();
        chk("wr_aw_w_valid", {awvalid, wvalid}, 2'b11);
        chk("wr_awaddr", awaddr, 32'h1C0001F1);
        chk("wr_awsize", awsize, 3'd0);
        chk("wr_wdata", wdata_axi, 32'h0000AB00);
        chk("wr_wstrb", wstrb_axi, 4'h2);
        step(); awready = 1'b0; settle();
        chk("wr_aw_drop", {awvalid, wvalid}, 2'b01);
        step(); wready = 1'b1; settle();
        chk("wr_w_hold", {awvalid, wvalid, bready}, 3'b010);
        step(); wready = 1'b0; bvalid = 1'b1; settle();
        chk("wr_bready", {wvalid, bready}, 2'b01);
        step(); bvalid = 1'b0; settle();
        chk("wr_data_ok", data_ok, 2'b10);
        step(); settle();
        chk("wr_data_ok_pulse", data_ok, 2'b00);

        // simultaneous requests, issued twice from a fresh pointer
        do_reset();
        step();
        req = 2'b11; wr = 2'b00; size = 4'b1010;
        addr = {32'h1C000200, 32'h1C000100};
        arready = 1'b1; rvalid = 1'b1; rdata_axi = 32'h11112222;
        settle();
        chk("arb1_grant", addr_ok, 2'b10);
        step(); req = 2'b01; settle();
        chk("arb1_busy", addr_ok, 2'b00);
        chk("arb1_araddr", araddr, 32'h1C000200);
        step(); step(); settle();
        chk("arb1_data_ok", data_ok, 2'b10);
        step(); req = 2'b11; settle();
`ifdef BRIDGE_DATA_PRIO_EN
        exp_second = 1'b1;
`else
        exp_second = 1'b0;
`endif
        chk("arb2_grant", addr_ok, exp_second ? 2'b10 : 2'b01);
        step(); req = 2'b00; settle();
        chk("arb2_araddr", araddr, exp_second ? 32'h1C000200 : 32'h1C000100);
        step(); step(); settle();
        chk("arb2_data_ok", data_ok, exp_second ? 2'b10 : 2'b01);

        // back-pressure on AR with a competing request waiting
        step();
        req = 2'b01; arready = 1'b0; rvalid = 1'b0;
        addr[31:0] = 32'h1C000300; addr[63:32] = 32'h1C000400;
        settle();
        chk("bp_addr_ok", addr_ok, 2'b01);
        step(); req = 2'b10;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_arvalid", arvalid, 1'b1);
            chk("bp_araddr", araddr, 32'h1C000300);
            chk("bp_no_addr_ok", addr_ok, 2'b00);
            step();
        end
        arready = 1'b1; rvalid = 1'b1; rdata_axi = 32'hA5A5A5A5;
        settle();
        chk("bp_release", arvalid, 1'b1);
        step(); settle();
        chk("bp_rready", rready, 1'b1);
        step(); settle();
        chk("bp_data_ok", {data_ok, addr_ok}, 4'b0100);
        chk("bp_rdata", rdata, 32'hA5A5A5A5);
        step(); settle();
        chk("bp_next_grant", addr_ok, 2'b10);
        step(); req = 2'b00; rdata_axi = 32'h5A5A5A5A;
        step(); step(); settle();
        chk("bp_next_data_ok", data_ok, 2'b10);
        chk("bp_next_rdata", rdata, 32'h5A5A5A5A);

        // reset while waiting in R
        step();
        req = 2'b01; addr[31:0] = 32'h1C000500; arready = 1'b1; rvalid = 1'b0;
        settle();
        chk("rst_addr_ok", addr_ok, 2'b01);
        step(); req = 2'b00; step(); settle();
        chk("rst_in_r", rready, 1'b1);
        reset = 1'b1;
        step(); reset = 1'b0; settle();
        chk_idle_outputs("rst_mid");
        step(); settle();
        chk("rst_no_data_ok", data_ok, 2'b00);
        step();
        req = 2'b01; addr[31:0] = 32'h1C000600; rvalid = 1'b1; rdata_axi = 32'h0BADF00D;
        settle();
        chk("rst_fresh_addr_ok", addr_ok, 2'b01);
        step(); req = 2'b00; settle();
        chk("rst_fresh_araddr", araddr, 32'h1C000600);
        step(); step(); settle();
        chk("rst_fresh_data_ok", data_ok, 2'b01);
        chk("rst_fresh_rdata", rdata, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
